// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: exception FSM states, cause codes, CP0 indices
// and the per-stage exception request record.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_HANDLER,
    S_ERET
  } exc_state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam int CP0_STATUS = 12;
  localparam int CP0_CAUSE  = 13;
  localparam int CP0_EPC    = 14;

  typedef struct packed {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] pc;
  } exc_req_t;

endpackage

// File: rtl/exc_prio.sv
// Exception winner select: oldest synchronous stage first (MEM > EX > ID),
// masked interrupts only when no stage is excepting.
module exc_prio
  import mips_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  exc_req_t             id_req,
  input  exc_req_t             ex_req,
  input  exc_req_t             mem_req,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic [NUM_IRQ-1:0]   irq_mask,
  output logic                 sync_vld,
  output logic                 win_vld,
  output logic [4:0]           win_cause,
  output logic [31:0]          win_pc
);

  logic irq_pend;

  always_comb begin
    irq_pend  = |(irq & irq_mask);
    sync_vld  = mem_req.exc | ex_req.exc | id_req.exc;
    win_vld   = sync_vld | irq_pend;
    // Interrupts are charged to the instruction in MEM
    win_cause = EXC_INT;
    win_pc    = mem_req.pc;
    if (mem_req.exc) begin
      win_cause = mem_req.cause;
      win_pc    = mem_req.pc;
    end else if (ex_req.exc) begin
      win_cause = ex_req.cause;
      win_pc    = ex_req.pc;
    end else if (id_req.exc) begin
      win_cause = id_req.cause;
      win_pc    = id_req.pc;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: picks a winner, pulses CP0, flushes the pipeline and
// redirects the PC; also sequences ERET back out of the handler.
module exc_ctrl
  import mips_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_exc,
  input  logic               ex_exc,
  input  logic               mem_exc,
  input  logic [4:0]         id_cause,
  input  logic [4:0]         ex_cause,
  input  logic [4:0]         mem_cause,
  input  logic [31:0]        id_pc,
  input  logic [31:0]        ex_pc,
  input  logic [31:0]        mem_pc,
  input  logic               mem_eret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        status,
  output logic               cp0_exception,
  output logic               cp0_eret,
  output logic [4:0]         cp0_cause,
  output logic [31:0]        cp0_pc,
  output logic               flush,
  output logic               pc_load,
  output logic               in_handler,
  output logic               double_fault
);

  exc_state_t  state_q, state_d;
  logic [4:0]  cause_q;
  logic [31:0] epc_q;
  logic        latch, set_df;
  logic        sync_vld, win_vld;
  logic [4:0]  win_cause;
  logic [31:0] win_pc;
  exc_req_t    id_req, ex_req, mem_req;
  logic        unused_status;

  assign id_req        = '{exc: id_exc,  cause: id_cause,  pc: id_pc};
  assign ex_req        = '{exc: ex_exc,  cause: ex_cause,  pc: ex_pc};
  assign mem_req       = '{exc: mem_exc, cause: mem_cause, pc: mem_pc};
  assign unused_status = ^status[31:NUM_IRQ];

  exc_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .id_req    (id_req),
    .ex_req    (ex_req),
    .mem_req   (mem_req),
    .irq       (irq),
    .irq_mask  (status[NUM_IRQ-1:0]),
    .sync_vld  (sync_vld),
    .win_vld   (win_vld),
    .win_cause (win_cause),
    .win_pc    (win_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      double_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cause_q <= win_cause;
        epc_q   <= win_pc;
      end
      if (set_df) double_fault <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    latch         = 1'b0;
    set_df        = 1'b0;
    cp0_exception = 1'b0;
    cp0_eret      = 1'b0;
    flush         = 1'b0;
    pc_load       = 1'b0;
    in_handler    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          latch   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cp0_exception = 1'b1;
        flush         = 1'b1;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush   = 1'b1;
        pc_load = 1'b1;
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        in_handler = 1'b1;
        // ERET sits in MEM, so it is older than any ID/EX request
        if (mem_eret) begin
          state_d = S_ERET;
        end else if (sync_vld) begin
          latch   = 1'b1;
          set_df  = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_ERET: begin
        cp0_eret = 1'b1;
        flush    = 1'b1;
        pc_load  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cp0_cause = cause_q;
  assign cp0_pc    = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a cycle-count model.
module tb_exc_ctrl;
  import mips_pkg::*;

  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_exc, ex_exc, mem_exc, mem_eret;
  logic [4:0]    id_cause, ex_cause, mem_cause;
  logic [31:0]   id_pc, ex_pc, mem_pc, status;
  logic [NI-1:0] irq;
  logic          cp0_exception, cp0_eret, flush, pc_load, in_handler, double_fault;
  logic [4:0]    cp0_cause;
  logic [31:0]   cp0_pc;

  int n_tests = 0;
  int n_fail  = 0;

  exc_ctrl #(.NUM_IRQ(NI)) dut (
    .clk(clk), .rst(rst),
    .id_exc(id_exc), .ex_exc(ex_exc), .mem_exc(mem_exc),
    .id_cause(id_cause), .ex_cause(ex_cause), .mem_cause(mem_cause),
    .id_pc(id_pc), .ex_pc(ex_pc), .mem_pc(mem_pc),
    .mem_eret(mem_eret), .irq(irq), .status(status),
    .cp0_exception(cp0_exception), .cp0_eret(cp0_eret),
    .cp0_cause(cp0_cause), .cp0_pc(cp0_pc),
    .flush(flush), .pc_load(pc_load), .in_handler(in_handler),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id_e, ex_e, mem_e, meret;
    logic [4:0]  idc, exc, memc;
    logic [31:0] idp, exp_, memp, st;
    logic [3:0]  irqv;
    logic        resp;
    logic [4:0]  e_cause;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] outs();
    return {cp0_exception, cp0_eret, flush, pc_load, in_handler, double_fault, cp0_cause, cp0_pc};
  endfunction

  task automatic clr();
    id_exc = 0; ex_exc = 0; mem_exc = 0; mem_eret = 0;
    id_cause = 0; ex_cause = 0; mem_cause = 0;
    id_pc = 0; ex_pc = 0; mem_pc = 0; irq = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  function automatic vec_t mk(logic id_e, logic [4:0] idc, logic [31:0] idp,
                              logic ex_e, logic [4:0] exc, logic [31:0] exp_,
                              logic mem_e, logic [4:0] memc, logic [31:0] memp,
                              logic meret, logic [3:0] irqv, logic [31:0] st,
                              logic resp, logic [4:0] e_cause, logic [31:0] e_pc);
    vec_t v;
    v.id_e = id_e; v.idc = idc; v.idp = idp;
    v.ex_e = ex_e; v.exc = exc; v.exp_ = exp_;
    v.mem_e = mem_e; v.memc = memc; v.memp = memp;
    v.meret = meret; v.irqv = irqv; v.st = st;
    v.resp = resp; v.e_cause = e_cause; v.e_pc = e_pc;
    return v;
  endfunction

  // Reference model: cycles elapsed since the exception was taken
  int          m_age;
  bit          m_ret, m_df;
  logic [4:0]  m_cause;
  logic [31:0] m_epc;

  task automatic model_step();
    bit          syn, win;
    logic [4:0]  c;
    logic [31:0] p;
    syn = mem_exc | ex_exc | id_exc;
    if (mem_exc)     begin c = mem_cause; p = mem_pc; end
    else if (ex_exc) begin c = ex_cause;  p = ex_pc;  end
    else if (id_exc) begin c = id_cause;  p = id_pc;  end
    else             begin c = EXC_INT;   p = mem_pc; end
    win = syn || ((irq & status[NI-1:0]) != 0);
    if (m_ret) m_ret = 0;
    else if (m_age == 0) begin
      if (win) begin m_age = 1; m_cause = c; m_epc = p; end
    end else if (m_age < 3) m_age++;
    else if (mem_eret) begin m_age = 0; m_ret = 1; end
    else if (syn) begin m_age = 1; m_cause = c; m_epc = p; m_df = 1; end
  endtask

  function automatic logic [42:0] model_outs();
    logic e, f, l, h;
    e = (m_age == 1);
    f = (m_age == 1) || (m_age == 2) || m_ret;
    l = (m_age == 2) || m_ret;
    h = (m_age >= 3);
    return {e, m_ret, f, l, h, m_df, m_cause, m_epc};
  endfunction

  initial begin
    vecs[0] = mk(0,0,0,          1,EXC_SYS,32'h00400010, 0,0,0,       0,4'b0000,32'hF,        1,EXC_SYS,32'h00400010);
    vecs[1] = mk(1,EXC_RI,32'h18, 1,EXC_OV,32'h14,       1,EXC_BP,32'h10, 0,4'b0000,32'hF,    1,EXC_BP,32'h10);
    vecs[2] = mk(0,0,0,          0,0,0,                  0,0,32'h20,  0,4'b0010,32'h0,        0,0,0);
    vecs[3] = mk(0,0,0,          0,0,0,                  0,0,32'h20,  0,4'b0010,32'hF,        1,EXC_INT,32'h20);
    vecs[4] = mk(0,0,0,          1,EXC_TR,32'h30,        0,0,32'h24,  0,4'b0010,32'hF,        1,EXC_TR,32'h30);
    vecs[5] = mk(0,0,0,          0,0,0,                  0,0,32'h28,  1,4'b0000,32'hF,        0,0,0);
    vecs[6] = mk(1,EXC_RI,32'h44, 0,0,0,                 0,0,32'h40,  0,4'b0000,32'hF,        1,EXC_RI,32'h44);
    vecs[7] = mk(0,0,0,          0,0,0,                  0,0,32'h50,  0,4'b1000,32'h7,        0,0,0);
    vecs[8] = mk(0,0,0,          0,0,0,                  0,0,32'h50,  0,4'b1000,32'hFFFFFFF8, 1,EXC_INT,32'h50);

    // Reset state
    clr(); status = 32'hF; rst = 1'b0;
    #12;
    chk("reset_outs", 64'(outs()), 64'd0);
    @(negedge clk); rst = 1'b1;
    step();

    // Single syscall with full timing
    ex_exc = 1; ex_cause = EXC_SYS; ex_pc = 32'h00400010;
    step(); clr();
    chk("sys_n1_ctl", {cp0_exception, flush, pc_load, in_handler}, 4'b1100);
    chk("sys_n1_cause", cp0_cause, EXC_SYS);
    chk("sys_n1_pc", cp0_pc, 32'h00400010);
    step();
    chk("sys_n2_ctl", {cp0_exception, flush, pc_load, in_handler}, 4'b0110);
    step();
    chk("sys_n3_ctl", {cp0_exception, flush, pc_load, in_handler}, 4'b0001);
    irq = 4'hF;
    step(); clr();
    chk("hdl_irq_ignored", {cp0_exception, flush, in_handler}, 3'b001);
    // ERET together with a younger EX request: ERET wins
    mem_eret = 1; ex_exc = 1; ex_cause = EXC_OV; ex_pc = 32'h77;
    step(); clr();
    chk("eret_ctl", {cp0_eret, flush, pc_load, in_handler, cp0_exception}, 5'b11100);
    chk("eret_cause_kept", cp0_cause, EXC_SYS);
    step();
    chk("eret_idle", {cp0_eret, flush, pc_load, in_handler, cp0_exception, double_fault}, 6'd0);

    // Request during FLUSH is dropped
    id_exc = 1; id_cause = EXC_RI; id_pc = 32'h18;
    step(); clr();
    ex_exc = 1; ex_cause = EXC_TR; ex_pc = 32'h99;
    step(); clr();
    chk("drop_cause", cp0_cause, EXC_RI);
    chk("drop_pc", cp0_pc, 32'h18);
    step();
    chk("drop_hdl", {cp0_exception, in_handler, double_fault}, 3'b010);
    step();
    chk("drop_no_retry", {cp0_exception, flush, in_handler}, 3'b001);

    // Nested exception from the handler
    ex_exc = 1; ex_cause = EXC_OV; ex_pc = 32'h14;
    step(); clr();
    chk("nest_n1", {cp0_exception, flush, in_handler, double_fault}, 4'b1101);
    chk("nest_cause", cp0_cause, EXC_OV);
    step(); step();
    chk("nest_hdl", {in_handler, double_fault}, 2'b11);
    mem_eret = 1;
    step(); clr();
    chk("nest_eret", cp0_eret, 1'b1);
    step();
    chk("df_sticky", {in_handler, double_fault}, 2'b01);

    // Reset asserted while in REDIRECT
    do_reset();
    ex_exc = 1; ex_cause = EXC_SYS; ex_pc = 32'h100;
    step(); clr();
    step();
    chk("rst_pre_redirect", {flush, pc_load}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outs", 64'(outs()), 64'd0);
    @(negedge clk); rst = 1'b1;
    step();
    chk("rst_after_1", 64'(outs()), 64'd0);
    step();
    chk("rst_after_2", 64'(outs()), 64'd0);

    // Table of single-cycle request patterns from IDLE
    foreach (vecs[i]) begin
      id_exc = vecs[i].id_e; id_cause = vecs[i].idc; id_pc = vecs[i].idp;
      ex_exc = vecs[i].ex_e; ex_cause = vecs[i].exc; ex_pc = vecs[i].exp_;
      mem_exc = vecs[i].mem_e; mem_cause = vecs[i].memc; mem_pc = vecs[i].memp;
      mem_eret = vecs[i].meret; irq = vecs[i].irqv; status = vecs[i].st;
      step(); clr(); status = 32'hF;
      chk($sformatf("vec%0d_resp", i), {cp0_exception, flush, cp0_eret}, {vecs[i].resp, vecs[i].resp, 1'b0});
      if (vecs[i].resp) begin
        chk($sformatf("vec%0d_cause", i), cp0_cause, vecs[i].e_cause);
        chk($sformatf("vec%0d_pc", i), cp0_pc, vecs[i].e_pc);
        step(); step();
        chk($sformatf("vec%0d_hdl", i), in_handler, 1'b1);
        mem_eret = 1;
        step(); clr();
        chk($sformatf("vec%0d_eret", i), cp0_eret, 1'b1);
        step();
      end
    end

    // Random traffic against the reference model
    do_reset();
    m_age = 0; m_ret = 0; m_df = 0; m_cause = 0; m_epc = 0;
    for (int c = 0; c < 2000; c++) begin
      id_exc   = ($urandom_range(0, 7) == 0);
      ex_exc   = ($urandom_range(0, 7) == 0);
      mem_exc  = ($urandom_range(0, 9) == 0);
      mem_eret = ($urandom_range(0, 5) == 0);
      id_cause = 5'($urandom); ex_cause = 5'($urandom); mem_cause = 5'($urandom);
      id_pc = $urandom; ex_pc = $urandom; mem_pc = $urandom;
      irq    = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
      status = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      model_step();
      step();
      chk($sformatf("rand_c%0d", c), 64'(outs()), 64'(model_outs()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
